idle_event_monitor: RTL and testbench
=====================================

Name: idle_event_monitor

Overview:
- Sits directly downstream of the line-idle sensor FSM and consumes its one-cycle `pulse` (eight consecutive zeros detected).
- Counts idle events inside a fixed observation window.
- Raises a sticky `alarm` when THRESH events land in one window, then holds it until firmware completes a 4-phase ack handshake.
- Keeps a saturating lifetime event count for status readout.

Parameters:
WINDOW, 64, window length in cycles including the opening pulse cycle (>=2)
THRESH, 4, events per window that trigger alarm (1..WINDOW)
CNT_W, 8, width of total_events

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous soft clear
pulse_in  in  1  single-cycle idle event from sensor stage
ack  in  1  alarm acknowledge, level, 4-phase
alarm  out  1  threshold reached, held until ack
win_count  out  $clog2(THRESH+1)  events counted in current window
total_events  out  CNT_W  lifetime events, saturating
overflow  out  1  sticky, set on increment attempt at saturation

Behaviour:
- Reset (reset_n=0, async): state IDLE; alarm=0, win_count=0, total_events=0, overflow=0, timer=0. All outputs are registered.
- clear=1 (sync): same values as reset at next edge. Overrides ack, pulse_in and all state transitions.
- total_events: +1 on every pulse_in=1, in every state.
  - At all-ones it holds, and overflow is set.
  - overflow is cleared only by reset or clear.
- FSM states: IDLE, WINDOW, ALARM, ACK_WAIT.
- IDLE:
  - pulse_in=1 -> win_count=1, timer=WINDOW-1, go to WINDOW.
  - If THRESH==1, go to ALARM instead.
- WINDOW:
  - timer decrements every cycle.
  - pulse_in=1 increments win_count.
  - If win_count+pulse_in == THRESH -> ALARM. alarm is high in the cycle after the threshold-reaching pulse (1-cycle latency).
  - Else if timer==1 (last window cycle) -> IDLE, win_count=0.
  - If the threshold pulse arrives on the last window cycle, ALARM wins.
  - A pulse in the cycle after expiry is handled by IDLE and opens a new window.
- ALARM:
  - alarm=1; win_count frozen at THRESH.
  - ack=1 sampled -> ACK_WAIT; alarm=0 next cycle.
- ACK_WAIT:
  - alarm=0.
  - Waits for ack=0, then goes to IDLE with win_count=0.
  - Pulses here update total_events only.
- ack outside ALARM/ACK_WAIT is ignored.
- Reset asserted mid-window or mid-alarm immediately forces the reset values; no event is retained.
- Width rules:
  - timer is $clog2(WINDOW) bits.
  - win_count never exceeds THRESH.
  - No arithmetic wraps anywhere.

Decomposition:
- Shared package idle_mon_pkg holds:
  - the state enum (IDLE, WINDOW, ALARM, ACK_WAIT) with 2-bit encoding;
  - width-derivation functions for timer and win_count.
- One sub-module: sat_counter, which carries parameter W and ports inc, clr, count and sat_hit. It implements total_events and overflow.
- The FSM, timer and win_count stay in the top module.

Test Plan:
- Bench defaults are WINDOW=8, THRESH=3 unless noted.
- Threshold hit: pulses at cycles 0, 2, 4 -> alarm=1 from cycle 5, win_count=3, total_events=3.
- Window expiry: pulses at cycles 0, 3, then none for 10 cycles -> state IDLE at cycle 8, win_count=0, alarm never set, total_events=2. A pulse at cycle 8 then gives win_count=1.
- Last-cycle threshold: pulses at cycles 0, 1, 7 -> alarm=1 at cycle 8 (no expiry).
- Ack handshake:
  - During ALARM, ack=1 for 3 cycles -> alarm=0 one cycle after ack is first sampled, and the state stays ACK_WAIT while ack=1.
  - A pulse during ACK_WAIT increments only total_events.
  - ack=0 -> IDLE, win_count=0.
- Saturation (CNT_W=4): 17 pulses spaced 10 cycles apart -> total_events=15, overflow=1. clear=1 then gives 0 and 0 next cycle.
- Clear/reset precedence:
  - In ALARM, clear=1 and ack=1 in the same cycle -> next cycle IDLE, alarm=0, all counters 0.
  - reset_n pulsed low mid-WINDOW between clock edges -> outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/idle_mon_pkg.sv
// Shared types and width helpers for the idle event monitor.
package idle_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WINDOW   = 2'd1,
    ST_ALARM    = 2'd2,
    ST_ACK_WAIT = 2'd3
  } mon_state_e;

  function automatic int timer_w(input int window);
    return $clog2(window);
  endfunction

  function automatic int wcnt_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag for increments attempted at full scale.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      sat_hit <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      sat_hit <= 1'b0;
    end else if (inc) begin
      if (count == MAX) sat_hit <= 1'b1;
      else              count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/idle_event_monitor.sv
// Counts idle pulses per observation window, raises a sticky alarm at THRESH
// events and releases it through a 4-phase ack handshake.
module idle_event_monitor
  import idle_mon_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         pulse_in,
  input  logic                         ack,
  output logic                         alarm,
  output logic [$clog2(THRESH+1)-1:0]  win_count,
  output logic [CNT_W-1:0]             total_events,
  output logic                         overflow
);

  localparam int TW = timer_w(WINDOW);
  localparam int CW = wcnt_w(THRESH);

  localparam logic [TW-1:0] T_LOAD = TW'(WINDOW - 1);
  localparam logic [TW-1:0] T_LAST = TW'(1);
  localparam logic [CW-1:0] WC_MAX = CW'(THRESH);
  localparam logic [CW-1:0] WC_ONE = CW'(1);

  mon_state_e    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] wc_nxt;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    wc_nxt    = win_count;
    if (clear) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
      wc_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pulse_in) begin
            wc_nxt    = WC_ONE;
            timer_nxt = T_LOAD;
            state_nxt = (THRESH == 1) ? ST_ALARM : ST_WINDOW;
          end
        end
        ST_WINDOW: begin
          if (timer != '0) timer_nxt = timer - 1'b1;
          // Threshold beats expiry when both land on the last window cycle.
          if (pulse_in && (win_count == WC_MAX - WC_ONE)) begin
            wc_nxt    = WC_MAX;
            state_nxt = ST_ALARM;
          end else begin
            if (pulse_in) wc_nxt = win_count + WC_ONE;
            if (timer == T_LAST) begin
              wc_nxt    = '0;
              timer_nxt = '0;
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_ALARM: begin
          if (ack) state_nxt = ST_ACK_WAIT;
        end
        ST_ACK_WAIT: begin
          if (!ack) begin
            wc_nxt    = '0;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          wc_nxt    = '0;
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      win_count <= '0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      win_count <= wc_nxt;
      alarm     <= (state_nxt == ST_ALARM);
    end
  end

  sat_counter #(.W(CNT_W)) u_total (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (pulse_in),
    .clr     (clear),
    .count   (total_events),
    .sat_hit (overflow)
  );

endmodule

// File: tb/tb_idle_event_monitor.sv
// Directed bench for idle_event_monitor: event-timeline model plus pinned literal checks.
module tb_idle_event_monitor;

  localparam int WINDOW = 8;
  localparam int THRESH = 3;

  logic       clk = 1'b0;
  logic       reset_n, clear, pulse_in, ack;
  logic       alarm, ovf, alarm_s, ovf_s;
  logic [1:0] wc, wc_s;
  logic [7:0] tot;
  logic [3:0] tot_s;

  always #5 clk = ~clk;

  idle_event_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pulse_in(pulse_in), .ack(ack),
    .alarm(alarm), .win_count(wc), .total_events(tot), .overflow(ovf)
  );

  idle_event_monitor #(.WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pulse_in(pulse_in), .ack(ack),
    .alarm(alarm_s), .win_count(wc_s), .total_events(tot_s), .overflow(ovf_s)
  );

  // Model: phase 0 idle, 1 window open, 2 alarmed, 3 waiting for ack release.
  // Window membership is by elapsed edges since the opening pulse; totals are
  // derived from the raw pulse count since the last clear.
  typedef struct {
    int ph;
    int cnt;
    int start;
    int cyc;
    int raw;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t s, input logic p, input logic a, input logic c);
    mdl_t n;
    n = s;
    n.cyc = s.cyc + 1;
    if (c) begin
      n.ph = 0; n.cnt = 0; n.raw = 0;
      return n;
    end
    if (p) n.raw = n.raw + 1;
    case (s.ph)
      0: if (p) begin
           n.cnt = 1; n.start = n.cyc;
           n.ph = (THRESH == 1) ? 2 : 1;
         end
      1: begin
           if (p) n.cnt = n.cnt + 1;
           if (n.cnt == THRESH) n.ph = 2;
           else if (n.cyc - s.start == WINDOW - 1) begin n.ph = 0; n.cnt = 0; end
         end
      2: if (a) n.ph = 3;
      3: if (!a) begin n.ph = 0; n.cnt = 0; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic int sat(input int raw, input int mx);
    return (raw > mx) ? mx : raw;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '{default: 0};
    else          m <= step(m, pulse_in, ack, clear);
  end

  // Pinned literal expectations; -1 means not checked.
  int pa, pw, pt, po, pts, pos;
  int pin_seq = 0;
  int pin_done = 0;
  bit started = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int got, input int exp);
    vectors = vectors + 1;
    if (got != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always begin
    @(negedge clk or negedge reset_n);
    #1;
    if (started) begin
      chk("alarm", int'(alarm), int'(m.ph == 2));
      chk("win_count", int'(wc), m.cnt);
      chk("total_events", int'(tot), sat(m.raw, 255));
      chk("overflow", int'(ovf), int'(m.raw > 255));
      chk("alarm_s", int'(alarm_s), int'(m.ph == 2));
      chk("win_count_s", int'(wc_s), m.cnt);
      chk("total_events_s", int'(tot_s), sat(m.raw, 15));
      chk("overflow_s", int'(ovf_s), int'(m.raw > 15));
      if (pin_seq != pin_done) begin
        if (pa  >= 0) chk("pin alarm", int'(alarm), pa);
        if (pw  >= 0) chk("pin win_count", int'(wc), pw);
        if (pt  >= 0) chk("pin total_events", int'(tot), pt);
        if (po  >= 0) chk("pin overflow", int'(ovf), po);
        if (pts >= 0) chk("pin total_events_s", int'(tot_s), pts);
        if (pos >= 0) chk("pin overflow_s", int'(ovf_s), pos);
        pin_done = pin_seq;
      end
    end
  end

  task automatic pin(input int a, input int w, input int t, input int o, input int ts, input int os);
    pa = a; pw = w; pt = t; po = o; pts = ts; pos = os;
    pin_seq = pin_seq + 1;
  endtask

  task automatic drive(input logic p, input logic a, input logic c);
    pulse_in = p; ack = a; clear = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; pulse_in = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    started = 1'b1;
    pin(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    idle(1);

    // Threshold hit, then ack handshake with a pulse while ack is held.
    drive(1, 0, 0); idle(1); drive(1, 0, 0); idle(1);
    pin(0, 2, 2, -1, -1, -1);
    drive(1, 0, 0);
    pin(1, 3, 3, 0, -1, -1);
    idle(2);
    pin(1, 3, 3, -1, -1, -1);
    drive(0, 1, 0);
    pin(0, 3, 3, -1, -1, -1);
    drive(1, 1, 0);
    pin(0, 3, 4, -1, -1, -1);
    drive(0, 1, 0);
    drive(0, 0, 0);
    pin(0, 0, 4, -1, -1, -1);

    // Window expiry with no further pulses.
    drive(1, 0, 0); idle(2); drive(1, 0, 0); idle(3);
    pin(0, 2, 6, -1, -1, -1);
    idle(1);
    pin(0, 0, 6, -1, -1, -1);
    idle(6);
    pin(0, 0, 6, -1, -1, -1);

    // Pulse on the first cycle after expiry opens a new window.
    drive(1, 0, 0); idle(2); drive(1, 0, 0); idle(4);
    drive(1, 0, 0);
    pin(0, 1, 9, -1, -1, -1);
    idle(8);
    pin(0, 0, 9, -1, -1, -1);

    // Threshold pulse on the last window cycle.
    drive(1, 0, 0); drive(1, 0, 0); idle(5);
    pin(0, 2, 11, -1, -1, -1);
    drive(1, 0, 0);
    pin(1, 3, 12, -1, -1, -1);

    // clear and ack together in ALARM: clear wins.
    drive(0, 1, 1);
    pin(0, 0, 0, 0, 0, 0);
    idle(2);

    // Async reset mid-window, between edges.
    drive(1, 0, 0);
    pin(0, 1, 1, -1, -1, -1);
    drive(0, 0, 0);
    #1;
    pin(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    idle(2);

    // Saturation of the narrow instance, then clear.
    for (int k = 0; k < 17; k++) begin
      drive(1, 0, 0);
      idle(9);
    end
    pin(0, 0, 17, 0, 15, 1);
    drive(0, 0, 1);
    pin(0, 0, 0, 0, 0, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
